// File: rtl/anode_scan_driver.sv
// Four-digit seven-segment anode scanner with per-slot blanking and a
// frame-consistent snapshot of the ALU result and operation number.
module anode_scan_driver #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       load,
    input  logic [7:0] YInput,
    input  logic [3:0] operation,
    output logic [3:0] anode,
    output logic [7:0] y_latched,
    output logic [3:0] op_latched,
    output logic [1:0] digit_idx,
    output logic       frame_done
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

    typedef enum logic {
        PARKED = 1'b0,
        SCAN   = 1'b1
    } mode_t;

    mode_t          mode;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  next_cnt;
    logic [1:0]     next_idx;
    logic           slot_end;
    logic           frame_end;
    logic           next_blank;
    logic           apply;
    logic           pending;
    logic [7:0]     y_shadow;
    logic [3:0]     op_shadow;

    assign mode = enable ? SCAN : PARKED;

    always_comb begin
        slot_end  = (cnt == LAST);
        frame_end = slot_end && (digit_idx == 2'd3);
        next_cnt  = slot_end ? '0 : cnt + CW'(1);
        next_idx  = slot_end ? digit_idx + 2'd1 : digit_idx;
        apply     = (mode == PARKED) || frame_end;
    end

    // Outputs are registered from the next-cycle counter so anode tracks cnt.
    generate
        if (BLANK_CYCLES == 0) begin : g_no_blank
            assign next_blank = 1'b0;
        end else begin : g_blank
            localparam logic [CW-1:0] BLANK_C = CW'(BLANK_CYCLES);
            assign next_blank = (next_cnt < BLANK_C);
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            digit_idx  <= 2'd0;
            anode      <= 4'b1111;
            frame_done <= 1'b0;
        end else begin
            case (mode)
                PARKED: begin
                    cnt        <= '0;
                    digit_idx  <= 2'd0;
                    anode      <= 4'b1111;
                    frame_done <= 1'b0;
                end
                SCAN: begin
                    cnt        <= next_cnt;
                    digit_idx  <= next_idx;
                    anode      <= next_blank ? 4'b1111 : ~(4'b0001 << next_idx);
                    frame_done <= (next_cnt == LAST) && (next_idx == 2'd3);
                end
                default: begin
                    cnt        <= '0;
                    digit_idx  <= 2'd0;
                    anode      <= 4'b1111;
                    frame_done <= 1'b0;
                end
            endcase
        end
    end

    // A load coinciding with an apply edge bypasses the shadow registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending    <= 1'b0;
            y_shadow   <= 8'd0;
            op_shadow  <= 4'd0;
            y_latched  <= 8'd0;
            op_latched <= 4'd0;
        end else begin
            if (load) begin
                y_shadow  <= YInput;
                op_shadow <= operation;
            end
            if (apply) begin
                if (load) begin
                    y_latched  <= YInput;
                    op_latched <= operation;
                end else if (pending) begin
                    y_latched  <= y_shadow;
                    op_latched <= op_shadow;
                end
                pending <= 1'b0;
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_anode_scan_driver.sv
// Directed bench for anode_scan_driver: rotation, blanking, frame-consistent
// loads, async reset, parking, and the zero-blank configuration.
module tb_anode_scan_driver;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       load;
    logic [7:0] y_in;
    logic [3:0] op_in;

    logic [3:0] anode_a, anode_b;
    logic [7:0] y_a, y_b;
    logic [3:0] op_a, op_b;
    logic [1:0] idx_a, idx_b;
    logic       fd_a, fd_b;

    int n_checks = 0;
    int n_pass   = 0;
    int k;

    anode_scan_driver #(.REFRESH_DIV(8), .BLANK_CYCLES(2)) dut_a (
        .clk(clk), .reset(reset), .enable(enable), .load(load),
        .YInput(y_in), .operation(op_in),
        .anode(anode_a), .y_latched(y_a), .op_latched(op_a),
        .digit_idx(idx_a), .frame_done(fd_a)
    );

    anode_scan_driver #(.REFRESH_DIV(2), .BLANK_CYCLES(0)) dut_b (
        .clk(clk), .reset(reset), .enable(enable), .load(load),
        .YInput(y_in), .operation(op_in),
        .anode(anode_b), .y_latched(y_b), .op_latched(op_b),
        .digit_idx(idx_b), .frame_done(fd_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, k);
    endtask

    task automatic step();
        @(negedge clk);
        k++;
    endtask

    // Expected A outputs for scan cycle c: 8-cycle slots, first 2 dark.
    task automatic check_rot_a(input int c);
        logic [3:0] one;
        logic [3:0] exp_an;
        int         idx;
        one    = 4'b0001;
        idx    = (c / 8) % 4;
        exp_an = ((c % 8) < 2) ? 4'b1111 : ~(one << idx);
        check("a_anode", {28'd0, anode_a}, {28'd0, exp_an});
        check("a_digit_idx", {30'd0, idx_a}, idx);
        check("a_frame_done", {31'd0, fd_a}, {31'd0, ((c % 32) == 31)});
    endtask

    // Expected B outputs: 2-cycle slots, never dark after the first cycle.
    task automatic check_rot_b(input int c);
        logic [3:0] one;
        int         idx;
        one = 4'b0001;
        idx = (c / 2) % 4;
        if (c >= 1) check("b_anode", {28'd0, anode_b}, {28'd0, ~(one << idx)});
        check("b_digit_idx", {30'd0, idx_b}, idx);
        check("b_frame_done", {31'd0, fd_b}, {31'd0, ((c % 8) == 7)});
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        load   = 1'b0;
        y_in   = 8'd0;
        op_in  = 4'd0;
        k      = 0;
        repeat (3) @(negedge clk);

        check("rst_anode", {28'd0, anode_a}, 32'hF);
        check("rst_digit", {30'd0, idx_a}, 32'd0);
        check("rst_y", {24'd0, y_a}, 32'd0);
        check("rst_op", {28'd0, op_a}, 32'd0);
        check("rst_fd", {31'd0, fd_a}, 32'd0);

        // Release reset and start scanning together; this cycle is cnt=0.
        reset  = 1'b0;
        enable = 1'b1;
        k      = 0;
        while (k <= 147) begin
            check_rot_a(k);
            check_rot_b(k);
            if (k <= 95)       check("y_old", {24'd0, y_a}, 32'h00);
            else if (k <= 127) check("y_frame", {24'd0, y_a}, 32'hA5);
            else               check("y_bound", {24'd0, y_a}, 32'h3C);
            check("op_val", {28'd0, op_a}, (k >= 128) ? 32'h7 : 32'h0);
            if (k == 75)  begin y_in = 8'hA5; load = 1'b1; end
            if (k == 76)  load = 1'b0;
            if (k == 127) begin y_in = 8'h3C; op_in = 4'h7; load = 1'b1; end
            if (k == 128) load = 1'b0;
            if (k == 147) break;
            step();
        end

        // Cycle 147 is mid-slot 2; reset must clear outputs before any edge.
        enable = 1'b0;
        reset  = 1'b1;
        #1;
        check("async_anode", {28'd0, anode_a}, 32'hF);
        check("async_digit", {30'd0, idx_a}, 32'd0);
        check("async_y", {24'd0, y_a}, 32'd0);
        check("async_op", {28'd0, op_a}, 32'd0);
        repeat (2) step();
        reset = 1'b0;
        step();

        y_in  = 8'h12;
        op_in = 4'h5;
        load  = 1'b1;
        step();
        load = 1'b0;
        check("park_y", {24'd0, y_a}, 32'h12);
        check("park_op", {28'd0, op_a}, 32'h5);
        for (int i = 0; i < 3; i++) begin
            check("park_anode", {28'd0, anode_a}, 32'hF);
            check("park_fd", {31'd0, fd_a}, 32'd0);
            check("park_digit", {30'd0, idx_a}, 32'd0);
            step();
        end

        enable = 1'b1;
        k      = 0;
        while (k <= 13) begin
            check_rot_a(k);
            if (k == 13) break;
            step();
        end
        enable = 1'b0;
        step();
        check("stop_anode", {28'd0, anode_a}, 32'hF);
        check("stop_digit", {30'd0, idx_a}, 32'd0);
        check("stop_y", {24'd0, y_a}, 32'h12);
        step();

        enable = 1'b1;
        k      = 0;
        while (k <= 9) begin
            check_rot_a(k);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
